multicycle_control: RTL

//  Multicycle MIPS-subset control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction.

---
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-subset control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK)
// Ports: clk, reset_n (async active-low); opcode/funct from IR; alu_zero; mem_ready handshake.
//   Datapath controls: ir_write, pc_write, pc_src, mem_read, mem_write, i_or_d, mem_to_reg,
//   reg_write, reg_dst, link_sel, alu_src_b, alu_cmd; status: instr_done, trap, instr_retired.
// Define CTRL_PERF_CNT_EN to build the instr_retired counter; otherwise it is tied to 0.
module multicycle_control #(
  parameter int CMD_W        = 3,
  parameter int MEM_WAIT_MAX = 15,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              alu_zero,
  input  logic              mem_ready,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              mem_read,
  output logic              mem_write,
  output logic              i_or_d,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic [1:0]        reg_dst,
  output logic              link_sel,
  output logic              alu_src_b,
  output logic [CMD_W-1:0]  alu_cmd,
  output logic              instr_done,
  output logic              trap,
  output logic [PERF_W-1:0] instr_retired
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;
  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(0), CMD_SUB = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_SLT = CMD_W'(2), CMD_XOR = CMD_W'(3);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    WB_ALU, BRANCH, JUMP, JUMP_REG, TRAP
  } state_t;
  state_t state, nxt;
  logic [5:0] op_q, fn_q;
  logic [7:0] wait_cnt;
  logic mem_st, timeout, jal;
  assign mem_st  = state inside {FETCH, MEM_RD, MEM_WR};
  // the cycle that would be the MEM_WAIT_MAX-th consecutive wait traps unless mem_ready arrives
  assign timeout = mem_st && !mem_ready && wait_cnt == 8'(MEM_WAIT_MAX - 1);
  assign jal     = op_q == OP_JAL;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
      op_q     <= '0;
      fn_q     <= '0;
    end else begin
      state    <= nxt;
      // counts only while parked in a memory state, so every entry starts from zero
      wait_cnt <= (mem_st && nxt == state) ? wait_cnt + 8'd1 : '0;
      if (state == DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  always_comb begin
    nxt = state;
    case (state)
      FETCH:    nxt = mem_ready ? DECODE : timeout ? TRAP : FETCH;
      DECODE:
        case (opcode)
          OP_R:          nxt = (funct inside {FN_ADD, FN_SUB, FN_SLT}) ? EXEC_R :
                               funct == FN_JR ? JUMP_REG : TRAP;
          OP_LW, OP_SW:  nxt = MEM_ADDR;
          OP_BNE:        nxt = BRANCH;
          OP_ADDI, OP_XORI: nxt = EXEC_I;
          OP_J, OP_JAL:  nxt = JUMP;
          default:       nxt = TRAP;
        endcase
      EXEC_R, EXEC_I: nxt = WB_ALU;
      MEM_ADDR: nxt = op_q == OP_LW ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = mem_ready ? MEM_WB : timeout ? TRAP : MEM_RD;
      MEM_WR:   nxt = mem_ready ? FETCH : timeout ? TRAP : MEM_WR;
      MEM_WB, WB_ALU, BRANCH, JUMP, JUMP_REG: nxt = FETCH;
      default:  nxt = TRAP;
    endcase
  end
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    link_sel   = 1'b0;
    alu_src_b  = 1'b0;
    alu_cmd    = CMD_ADD;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      EXEC_R:   alu_cmd = fn_q == FN_SUB ? CMD_SUB : fn_q == FN_SLT ? CMD_SLT : CMD_ADD;
      EXEC_I: begin
        alu_src_b = 1'b1;
        alu_cmd   = op_q == OP_XORI ? CMD_XOR : CMD_ADD;
      end
      WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = op_q == OP_R ? 2'd1 : 2'd0;
        instr_done = 1'b1;
      end
      MEM_ADDR: alu_src_b = 1'b1;
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      BRANCH: begin
        alu_cmd    = CMD_SUB;
        pc_src     = 2'd1;
        pc_write   = !alu_zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        reg_write  = jal;
        reg_dst    = jal ? 2'd2 : 2'd0;
        link_sel   = jal;
        instr_done = 1'b1;
      end
      JUMP_REG: begin
        pc_write   = 1'b1;
        pc_src     = 2'd3;
        instr_done = 1'b1;
      end
      TRAP:     trap = 1'b1;
      default:  ;
    endcase
  end
`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) instr_retired <= '0;
    else if (instr_done) instr_retired <= instr_retired + PERF_W'(1);
`else
  assign instr_retired = '0;
`endif
endmodule
